// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead block per stage,
// registered group carry between stages, valid/ready handshake with global stall.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTG = WIDTH / GROUP;

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Every carry is a flat sum of products of g/p terms and the group carry-in.
    function automatic logic [GROUP:0] lookahead(
        input logic [GROUP-1:0] g,
        input logic [GROUP-1:0] p,
        input logic             c0
    );
        logic [GROUP:0] c;
        logic           term;
        c    = '0;
        c[0] = c0;
        for (int j = 1; j <= GROUP; j++) begin
            term = c0;
            for (int n = 0; n < j; n++) term &= p[n];
            c[j] = term;
            for (int m = 0; m < j; m++) begin
                term = g[m];
                for (int n = m + 1; n < j; n++) term &= p[n];
                c[j] |= term;
            end
        end
        return c;
    endfunction

    for (genvar k = 0; k < NSTG; k++) begin : stage
        localparam int LO = k * GROUP;
        localparam int BW = WIDTH - LO;

        logic             valid_q;
        logic [WIDTH-1:0] word_q;   // finished sum bits below LO, operand A bits from LO up
        logic [BW-1:0]    b_q;      // only the operand B bits not yet consumed
        logic             c_q;
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic [WIDTH-1:0] nxt_w;

        assign g = word_q[LO +: GROUP] & b_q[GROUP-1:0];
        assign p = word_q[LO +: GROUP] ^ b_q[GROUP-1:0];
        assign c = lookahead(g, p, c_q);

        always_comb begin
            nxt_w              = word_q;
            nxt_w[LO +: GROUP] = p ^ c[GROUP-1:0];
        end

        if (k == 0) begin : head
            always_ff @(posedge clk) begin
                if (!rst_n)   valid_q <= 1'b0;
                else if (adv) valid_q <= in_valid;
            end

            // NOTE: datapath registers carry no reset; only the valid bits decide what is live.
            always_ff @(posedge clk) begin
                if (adv) begin
                    word_q <= a;
                    b_q    <= op ? ~b : b;
                    c_q    <= op | cin;
                end
            end
        end else begin : body
            always_ff @(posedge clk) begin
                if (!rst_n)   valid_q <= 1'b0;
                else if (adv) valid_q <= stage[k-1].valid_q;
            end

            always_ff @(posedge clk) begin
                if (adv) begin
                    word_q <= stage[k-1].nxt_w;
                    b_q    <= stage[k-1].b_q[BW+GROUP-1:GROUP];
                    c_q    <= stage[k-1].c[GROUP];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (adv) begin
            out_valid <= stage[NSTG-1].valid_q;
            sum       <= stage[NSTG-1].nxt_w;
            cout      <= stage[NSTG-1].c[GROUP];
            ovf       <= stage[NSTG-1].c[GROUP-1] ^ stage[NSTG-1].c[GROUP];
        end
    end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. It is the next generation of the team's 4-bit combinational CLA.
- Splits a WIDTH-bit operation into GROUP-bit lookahead blocks, one block per pipeline stage, with a registered group carry between stages.
- Valid/ready handshake on input and output, so it drops into streaming datapaths with backpressure. Throughput is 1 operation/cycle.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of GROUP.
- GROUP, 4, bits per lookahead block (per pipeline stage); 1 <= GROUP <= WIDTH.
- NSTG (derived, localparam), WIDTH/GROUP, number of pipeline stages, which is also the latency.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in; ignored when op=1.
- op  in  1  0 = add (a+b+cin), 1 = subtract (a-b, computed as a+~b+1).
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB; for subtract, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset: while rst_n=0 at a clk edge, all stage valid bits clear, out_valid=0, sum=0, cout=0, ovf=0. in_ready is combinational and reads 1 once out_valid=0.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. All stages shift together when adv=1 and hold all contents when adv=0.
- Acceptance: a beat is accepted when in_valid && in_ready. When adv=1 and in_valid=0, a bubble (valid=0) enters stage 0.
- Stage 0 latches a, b_eff, c0 and valid.
  - b_eff = op ? ~b : b.
  - c0 = op ? 1 : cin.
- Stage k (0..NSTG-1) computes group k (bits k*GROUP+GROUP-1 : k*GROUP) from the group carry held in its register.
  - Inside a group: g_i = a_i & b_i; p_i = a_i ^ b_i; c_{i+1} = g_i | p_i & c_i, expanded in lookahead form (no ripple chain required, but the result must be identical).
  - Group sum bits are s_i = p_i ^ c_i.
  - Sum bits already computed, the remaining operand bits and the group carry-out pass to stage k+1.
- Output register holds the final stage.
  - sum = concatenated group sums.
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Latency: a beat accepted at edge T appears with out_valid=1 after edge T+NSTG-1+1, i.e. NSTG cycles, provided adv stays 1.
- Each stall cycle (out_valid && !out_ready) adds exactly one cycle of latency to every in-flight beat.
- Ordering: results leave in acceptance order, with no loss and no duplication.
- Output stability: while out_valid=1 and out_ready=0, sum/cout/ovf/out_valid hold stable.
- Bubble behaviour: bubbles do not raise out_valid. Data registers may update on bubbles, but sum/cout/ovf are only meaningful when out_valid=1.
- Wrap-around: results are modulo 2^WIDTH; overflow is reported only through cout/ovf.
- Reset mid-operation: every in-flight beat is discarded. out_valid=0 on the cycle after the reset edge, and no pre-reset result ever appears afterwards.
- Degenerate GROUP=WIDTH: NSTG=1, giving a single-stage registered CLA with latency 1.

Test Plan (WIDTH=16, GROUP=4, NSTG=4):
1. Reset: hold rst_n=0 for 2 edges with in_valid=1 -> out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 after release.
2. Full carry propagation: a=0xFFFF, b=0x0001, cin=0, op=0, out_ready=1 -> exactly 4 cycles later sum=0x0000, cout=1, ovf=0. Then a=0x0006, b=0x000D, cin=1 -> sum=0x0014, cout=0.
3. Signed overflow:
   - a=0x7FFF + b=0x0001, op=0 -> sum=0x8000, cout=0, ovf=1.
   - a=0x8000 - b=0x0001, op=1, cin=1 (ignored) -> sum=0x7FFF, cout=1, ovf=1.
   - a=0x0003 - b=0x0005, op=1 -> sum=0xFFFE, cout=0, ovf=0.
4. Backpressure: stream 8 back-to-back random beats while out_ready follows the pattern 1,0,0,1,0,1,1,1... -> in_ready equals adv every cycle; outputs stay stable during stalls; all 8 results match the reference model (a+b+cin or a-b) in order, with no duplicates.
5. Reset mid-flight: accept 3 beats, then pull rst_n=0 for 1 edge -> out_valid=0 the next cycle; none of the 3 results ever appear; a new beat accepted afterwards emerges after 4 cycles and is correct.
6. Parameter sweep: rerun scenarios 2 and 3 scaled to WIDTH=8/GROUP=8 (latency 1) and WIDTH=32/GROUP=4 (latency 8) -> same flag behaviour, and latency equals NSTG.
